// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game sequencer: FSM encodings and
// two-digit BCD arithmetic used by the score and hiscore paths.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] BCD_MAX  = 8'h99;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = {3'b000, bcd[7:4]};
    units = {3'b000, bcd[3:0]};
    return tens * 7'd10 + units;
  endfunction

  // Saturating +1; 99 stays 99, units 9 rolls into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    if (bcd >= BCD_MAX) begin
      return BCD_MAX;
    end
    if (bcd[3:0] >= 4'd9) begin
      return {bcd[7:4] + 4'd1, 4'd0};
    end
    return {bcd[7:4], bcd[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and increment enable,
// saturating at 99.
module bcd2_counter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value
);

  logic [7:0] value_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      value_reg <= BCD_ZERO;
    end else if (inc) begin
      value_reg <= bcd_inc(value_reg);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: start/clear control, speed-scaled movement tick and BCD score.
// Optional best-score tracking is enabled by defining SNAKE_HISCORE_EN.
module game_controller
  import snake_pkg::*;
#(
  parameter int CNT_W       = 22,
  parameter int BASE_PERIOD = 2_500_000,
  parameter int STEP        = 100_000,
  parameter int MIN_PERIOD  = 500_000,
  parameter int CLEAR_CYC   = 4
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       game_over,
  input  logic       apple_eaten,
  output logic       start,
  output logic       update,
  output logic [1:0] state,
  output logic [7:0] score_bcd,
  output logic [7:0] hiscore_bcd
);

  localparam int SYNC_STAGES = 2;
  localparam int PW          = CNT_W + 8;
  localparam int CLR_W       = $clog2(CLEAR_CYC + 1);

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] btn_sync_reg;
  logic                   btn_prev_reg;
  logic                   apple_prev_reg;
  logic                   btn_pe, eat_pe;
  logic [CNT_W-1:0]       tick_cnt_reg;
  logic [CLR_W-1:0]       clr_cnt_reg;
  logic [PW-1:0]          dec_w, per_w;
  logic [CNT_W-1:0]       period_m1;
  logic                   tick_hit, clear_done, in_play;
  logic                   score_inc, score_clr;

  // Button crosses in from an asynchronous pin: plain flop chain.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_btn_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge VGA_clk) begin
          if (rst) btn_sync_reg[gi] <= 1'b0;
          else     btn_sync_reg[gi] <= btn_start;
        end
      end else begin : g_rest
        always_ff @(posedge VGA_clk) begin
          if (rst) btn_sync_reg[gi] <= 1'b0;
          else     btn_sync_reg[gi] <= btn_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge VGA_clk) begin
    if (rst) begin
      btn_prev_reg   <= 1'b0;
      apple_prev_reg <= 1'b0;
    end else begin
      btn_prev_reg   <= btn_sync_reg[SYNC_STAGES-1];
      apple_prev_reg <= apple_eaten;
    end
  end

  assign btn_pe = btn_sync_reg[SYNC_STAGES-1] & ~btn_prev_reg;
  assign eat_pe = apple_eaten & ~apple_prev_reg;

  // Wide arithmetic so a large score clamps instead of wrapping below zero.
  assign dec_w = PW'(STEP) * PW'(bcd_to_bin(score_bcd));

  always_comb begin
    if (dec_w + PW'(MIN_PERIOD) > PW'(BASE_PERIOD)) begin
      per_w = PW'(MIN_PERIOD);
    end else begin
      per_w = PW'(BASE_PERIOD) - dec_w;
    end
  end

  assign period_m1  = CNT_W'(per_w - PW'(1));
  assign tick_hit   = tick_cnt_reg >= period_m1;
  assign in_play    = state_reg == ST_PLAY;
  assign clear_done = clr_cnt_reg == CLR_W'(CLEAR_CYC - 1);

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    update     = 1'b0;
    score_inc  = 1'b0;
    score_clr  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (btn_pe) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        score_clr = 1'b1;
        if (clear_done) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        start     = 1'b1;
        update    = tick_hit & ~game_over;
        score_inc = eat_pe;
        if (game_over) state_next = ST_OVER;
      end
      ST_OVER: begin
        start = 1'b1;
        if (btn_pe) state_next = ST_CLEAR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      clr_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      // An over-range count after a speed-up fires on the very next cycle.
      if (!in_play || tick_hit) tick_cnt_reg <= '0;
      else                      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
      if (state_reg == ST_CLEAR && !clear_done) clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
      else                                      clr_cnt_reg <= '0;
    end
  end

  bcd2_counter u_score (
    .clk  (VGA_clk),
    .srst (rst),
    .clr  (score_clr),
    .inc  (score_inc),
    .value(score_bcd)
  );

`ifdef SNAKE_HISCORE_EN
  logic [7:0] hiscore_reg;
  logic [7:0] final_score;

  // Include a point scored in the same cycle as the fatal collision.
  assign final_score = score_inc ? bcd_inc(score_bcd) : score_bcd;

  always_ff @(posedge VGA_clk) begin
    if (rst) begin
      hiscore_reg <= BCD_ZERO;
    end else if (in_play && game_over && final_score > hiscore_reg) begin
      hiscore_reg <= final_score;
    end
  end

  assign hiscore_bcd = hiscore_reg;
`else
  assign hiscore_bcd = BCD_ZERO;
`endif

  assign state = state_reg;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the game rules.
module tb_game_controller;

  localparam int BASE = 20;
  localparam int STP  = 4;
  localparam int MINP = 8;
  localparam int CLRC = 4;
`ifdef SNAKE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       VGA_clk = 1'b0;
  logic       rst = 1'b0, btn_start = 1'b0, game_over = 1'b0, apple_eaten = 1'b0;
  logic       start, update;
  logic [1:0] state;
  logic [7:0] score_bcd, hiscore_bcd;

  always #5 VGA_clk = ~VGA_clk;

  game_controller #(
    .CNT_W(22), .BASE_PERIOD(BASE), .STEP(STP), .MIN_PERIOD(MINP), .CLEAR_CYC(CLRC)
  ) dut (
    .VGA_clk    (VGA_clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .game_over  (game_over),
    .apple_eaten(apple_eaten),
    .start      (start),
    .update     (update),
    .state      (state),
    .score_bcd  (score_bcd),
    .hiscore_bcd(hiscore_bcd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 idle, 1 clearing, 2 playing, 3 game over.
  int       m_mode, m_score, m_hi, m_since, m_clr;
  logic [2:0] m_btn_hist;
  logic     m_apple_prev;

  logic       o_start, o_update;
  logic [1:0] o_state;
  logic [7:0] o_score, o_hi;
  logic       e_start, e_update;
  logic [1:0] e_state;
  logic [7:0] e_score, e_hi;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int period_of(input int s);
    int p;
    p = BASE - STP * s;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_hi = 0; m_since = 0; m_clr = 0;
    m_btn_hist = 3'b000; m_apple_prev = 1'b0;
  endtask

  // Advance the model over one rising edge with the inputs sampled there.
  task automatic model_step(input logic b, input logic a, input logic g, input logic r);
    logic bpe, eat;
    bpe = m_btn_hist[1] & ~m_btn_hist[2];
    eat = a & ~m_apple_prev;
    m_btn_hist = {m_btn_hist[1:0], b};
    m_apple_prev = a;
    if (r) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (bpe) begin m_mode = 1; m_clr = 0; end
      1: begin
        m_score = 0;
        m_clr++;
        if (m_clr == CLRC) begin m_mode = 2; m_since = 0; end
      end
      2: begin
        if (g) begin
          if (eat && m_score < 99) m_score++;
          if (m_score > m_hi) m_hi = m_score;
          m_mode = 3;
        end else begin
          if (m_since + 1 >= period_of(m_score)) m_since = 0;
          else m_since++;
          if (eat && m_score < 99) m_score++;
        end
      end
      default: if (bpe) begin m_mode = 1; m_clr = 0; end
    endcase
  endtask

  // Drive one cycle; outputs and model expectations are captured at the falling edge.
  task automatic step(input logic b, input logic a, input logic g, input logic r);
    btn_start = b; apple_eaten = a; game_over = g; rst = r;
    @(negedge VGA_clk);
    o_state = state; o_start = start; o_update = update; o_score = score_bcd; o_hi = hiscore_bcd;
    e_state  = 2'(m_mode);
    e_start  = (m_mode == 2) || (m_mode == 3);
    e_update = (m_mode == 2) && !g && (m_since + 1 >= period_of(m_score));
    e_score  = 8'(to_bcd(m_score));
    e_hi     = HI_EN ? 8'(to_bcd(m_hi)) : 8'h00;
    @(posedge VGA_clk);
    model_step(b, a, g, r);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic apple_pulse();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic start_game(output bit ok);
    ok = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (o_state == 2'd2) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_update(input int limit, output int cycles, output bit ok);
    ok = 1'b0; cycles = 0;
    for (int i = 0; i < limit; i++) begin
      step(0, 0, 0, 0);
      cycles++;
      if (o_update) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_cmp++; if (o_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", o_start); end
    n_cmp++; if (o_update !== 1'b0) begin n_bad++; $display("FAIL reset_update: got %b want 0", o_update); end
    n_cmp++; if (o_score !== 8'h00) begin n_bad++; $display("FAIL reset_score: got %h want 00", o_score); end
    n_cmp++; if (o_hi !== 8'h00) begin n_bad++; $display("FAIL reset_hiscore: got %h want 00", o_hi); end
    $display("test_reset: done (%0d compared)", n_cmp);
  endtask

  task automatic test_start();
    int n_clear, k;
    bit got;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL start_latency_early: got state %0d want 0", o_state); end
    step(0, 0, 0, 0);
    n_cmp++; if (o_state !== 2'd1) begin n_bad++; $display("FAIL start_latency: got state %0d want 1", o_state); end
    n_clear = 0;
    for (int i = 0; i < 10 && o_state == 2'd1; i++) begin
      n_clear++;
      n_cmp++; if (o_start !== 1'b0) begin n_bad++; $display("FAIL clear_start_low: got %b want 0", o_start); end
      step(0, 0, 0, 0);
    end
    n_cmp++; if (n_clear != CLRC) begin n_bad++; $display("FAIL clear_length: got %0d want %0d", n_clear, CLRC); end
    n_cmp++; if (o_state !== 2'd2 || o_start !== 1'b1) begin n_bad++; $display("FAIL play_entry: got state %0d start %b want 2 1", o_state, o_start); end
    k = 0; got = o_update;
    while (!got && k < 60) begin
      step(0, 0, 0, 0);
      k++;
      got = o_update;
    end
    n_cmp++; if (!got || k + 1 != BASE) begin n_bad++; $display("FAIL first_update: got %0d cycles want %0d", k + 1, BASE); end
    $display("test_start: first update after %0d play cycles", k + 1);
  endtask

  task automatic test_speedup();
    int gap;
    bit ok;
    apple_pulse();
    wait_update(60, gap, ok);
    wait_update(60, gap, ok);
    n_cmp++; if (!ok || gap != 16) begin n_bad++; $display("FAIL spacing_score1: got %0d want 16 (seen %b)", gap, ok); end
    apple_pulse();
    apple_pulse();
    n_cmp++; if (o_score !== 8'h03) begin n_bad++; $display("FAIL speed_score: got %h want 03", o_score); end
    wait_update(60, gap, ok);
    wait_update(60, gap, ok);
    n_cmp++; if (!ok || gap != 8) begin n_bad++; $display("FAIL spacing_score3: got %0d want 8 (seen %b)", gap, ok); end
    $display("test_speedup: spacing at score 3 = %0d", gap);
  endtask

  task automatic test_carry();
    bit ok;
    do_reset();
    start_game(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL carry_reach_play: got state %0d want 2", o_state); end
    for (int i = 0; i < 9; i++) apple_pulse();
    n_cmp++; if (o_score !== 8'h09) begin n_bad++; $display("FAIL score_9: got %h want 09", o_score); end
    apple_pulse();
    n_cmp++; if (o_score !== 8'h10) begin n_bad++; $display("FAIL score_carry: got %h want 10", o_score); end
    for (int i = 0; i < 95; i++) apple_pulse();
    n_cmp++; if (o_score !== 8'h99) begin n_bad++; $display("FAIL score_saturate: got %h want 99", o_score); end
    $display("test_carry: final score %h", o_score);
  endtask

  task automatic test_game_over();
    bit ok;
    int n_upd;
    do_reset();
    start_game(ok);
    for (int i = 0; i < 5; i++) apple_pulse();
    n_cmp++; if (o_score !== 8'h05) begin n_bad++; $display("FAIL over_pre_score: got %h want 05", o_score); end
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    n_cmp++; if (o_state !== 2'd3 || o_start !== 1'b1) begin n_bad++; $display("FAIL over_state: got state %0d start %b want 3 1", o_state, o_start); end
    n_cmp++; if (o_score !== 8'h06) begin n_bad++; $display("FAIL over_same_cycle_point: got %h want 06", o_score); end
    n_cmp++; if (o_hi !== (HI_EN ? 8'h06 : 8'h00)) begin n_bad++; $display("FAIL hiscore_first: got %h want %h", o_hi, HI_EN ? 8'h06 : 8'h00); end
    n_upd = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1, 0);
      if (o_update) n_upd++;
    end
    n_cmp++; if (n_upd != 0) begin n_bad++; $display("FAIL over_no_update: got %0d ticks want 0", n_upd); end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (o_state !== 2'd1 || o_score !== 8'h00) begin n_bad++; $display("FAIL restart_clear: got state %0d score %h want 1 00", o_state, o_score); end
    for (int i = 0; i < 10 && o_state != 2'd2; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apple_pulse();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (o_state !== 2'd3 || o_score !== 8'h04) begin n_bad++; $display("FAIL second_game: got state %0d score %h want 3 04", o_state, o_score); end
    n_cmp++; if (o_hi !== (HI_EN ? 8'h06 : 8'h00)) begin n_bad++; $display("FAIL hiscore_keep: got %h want %h", o_hi, HI_EN ? 8'h06 : 8'h00); end
    $display("test_game_over: hiscore %h", o_hi);
  endtask

  task automatic test_midgame_rst();
    bit ok;
    do_reset();
    start_game(ok);
    for (int i = 0; i < 12; i++) apple_pulse();
    n_cmp++; if (o_score !== 8'h12) begin n_bad++; $display("FAIL midrst_pre_score: got %h want 12", o_score); end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_cmp++; if (o_state !== 2'd0 || o_start !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got state %0d start %b want 0 0", o_state, o_start); end
    n_cmp++; if (o_score !== 8'h00 || o_update !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got score %h update %b want 00 0", o_score, o_update); end
    $display("test_midgame_rst: state %0d score %h", o_state, o_score);
  endtask

  task automatic test_random();
    logic b, a, g, r;
    int bad0;
    bad0 = n_bad;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      b = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 3) == 0);
      g = (m_mode == 2) ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 2) == 0);
      step(b, a, g, r);
      n_cmp++; if (o_state !== e_state) begin n_bad++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, o_state, e_state); end
      n_cmp++; if (o_start !== e_start) begin n_bad++; $display("FAIL rnd_start @%0d: got %b want %b", i, o_start, e_start); end
      n_cmp++; if (o_update !== e_update) begin n_bad++; $display("FAIL rnd_update @%0d: got %b want %b", i, o_update, e_update); end
      n_cmp++; if (o_score !== e_score) begin n_bad++; $display("FAIL rnd_score @%0d: got %h want %h", i, o_score, e_score); end
      n_cmp++; if (o_hi !== e_hi) begin n_bad++; $display("FAIL rnd_hiscore @%0d: got %h want %h", i, o_hi, e_hi); end
    end
    $display("test_random: 3000 cycles, %0d new mismatches", n_bad - bad0);
  endtask

  initial begin
    model_reset();
    @(posedge VGA_clk);
    #1;
    test_reset();
    test_start();
    test_speedup();
    test_carry();
    test_game_over();
    test_midgame_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
